// File: rtl/operand_stage_pkg.sv
// Shared types for the operand stage: default widths, forwarding source
// and micro-op bundles, and the stage occupancy encoding.
package operand_stage_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_W_DEF  = 5;
    localparam int NFWD_DEF   = 3;
    localparam int CTRL_W_DEF = 12;
    localparam int CNT_W_DEF  = 32;

    typedef struct packed {
        logic                 valid;
        logic                 avail;
        logic [REG_W_DEF-1:0] dst;
        logic [XLEN_DEF-1:0]  data;
    } fwd_src_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0]   pc;
        logic [REG_W_DEF-1:0]  src1;
        logic [REG_W_DEF-1:0]  src2;
        logic                  use1;
        logic                  use2;
        logic [REG_W_DEF-1:0]  dst;
        logic [XLEN_DEF-1:0]   imm;
        logic [CTRL_W_DEF-1:0] ctrl;
    } uop_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_INTERLOCK
    } stage_state_t;

endpackage

// File: rtl/operand_stage_fwd_mux.sv
// Priority forwarding select for one source operand: youngest matching
// producer wins, and an unavailable youngest match raises a hazard.
module operand_fwd_mux
    import operand_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int REG_W = REG_W_DEF,
    parameter int NFWD  = NFWD_DEF
) (
    input  logic                  use_src,
    input  logic [REG_W-1:0]      src,
    input  logic [XLEN-1:0]       rf_data,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD-1:0]       fwd_avail,
    input  logic [NFWD*REG_W-1:0] fwd_dst,
    input  logic [NFWD*XLEN-1:0]  fwd_data,
    output logic [XLEN-1:0]       operand,
    output logic                  hazard
);

    logic [NFWD-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NFWD; i++) begin
            hit[i] = fwd_valid[i]
                  && (fwd_dst[i*REG_W +: REG_W] == src)
                  && (fwd_dst[i*REG_W +: REG_W] != '0);
        end
    end

    // Walk oldest to youngest so the lowest matching index is applied last.
    always_comb begin
        operand = rf_data;
        hazard  = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (hit[i]) begin
                operand = fwd_data[i*XLEN +: XLEN];
                hazard  = !fwd_avail[i];
            end
        end
        if (!use_src || (src == '0)) begin
            operand = '0;
            hazard  = 1'b0;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// Operand stage: holds one decoded op, resolves its sources from the
// regfile or forwarding network, interlocks, and hands off to execute.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int NFWD   = NFWD_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_W-1:0]      in_src1,
    input  logic [REG_W-1:0]      in_src2,
    input  logic                  in_use1,
    input  logic                  in_use2,
    input  logic [REG_W-1:0]      in_dst,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic                  flush,
    output logic [REG_W-1:0]      rf_idx1,
    output logic [REG_W-1:0]      rf_idx2,
    input  logic [XLEN-1:0]       rf_data1,
    input  logic [XLEN-1:0]       rf_data2,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD-1:0]       fwd_avail,
    input  logic [NFWD*REG_W-1:0] fwd_dst,
    input  logic [NFWD*XLEN-1:0]  fwd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_imm,
    output logic [XLEN-1:0]       out_op1,
    output logic [XLEN-1:0]       out_op2,
    output logic                  out_eq,
    output logic [REG_W-1:0]      out_dst,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_W-1:0]  src1;
        logic [REG_W-1:0]  src2;
        logic              use1;
        logic              use2;
        logic [REG_W-1:0]  dst;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
    } held_t;

    held_t             held_q;
    held_t             held_d;
    logic              hold_valid_q;
    logic              hold_valid_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    stage_state_t      state;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic              hazard1;
    logic              hazard2;
    logic              hazard;
    logic              fire;
    logic              accept;

    operand_fwd_mux #(
        .XLEN  (XLEN),
        .REG_W (REG_W),
        .NFWD  (NFWD)
    ) u_mux1 (
        .use_src   (held_q.use1),
        .src       (held_q.src1),
        .rf_data   (rf_data1),
        .fwd_valid (fwd_valid),
        .fwd_avail (fwd_avail),
        .fwd_dst   (fwd_dst),
        .fwd_data  (fwd_data),
        .operand   (op1),
        .hazard    (hazard1)
    );

    operand_fwd_mux #(
        .XLEN  (XLEN),
        .REG_W (REG_W),
        .NFWD  (NFWD)
    ) u_mux2 (
        .use_src   (held_q.use2),
        .src       (held_q.src2),
        .rf_data   (rf_data2),
        .fwd_valid (fwd_valid),
        .fwd_avail (fwd_avail),
        .fwd_dst   (fwd_dst),
        .fwd_data  (fwd_data),
        .operand   (op2),
        .hazard    (hazard2)
    );

    assign hazard = hazard1 || hazard2;

    // FULL vs INTERLOCK is re-derived every cycle from live forwarding state.
    always_comb begin
        state = ST_EMPTY;
        if (hold_valid_q) begin
            state = hazard ? ST_INTERLOCK : ST_FULL;
        end
    end

    always_comb begin
        out_valid = (state == ST_FULL);
        fire      = out_valid && out_ready;
        in_ready  = !flush && ((state == ST_EMPTY) || fire);
        accept    = in_valid && in_ready;
        rf_idx1   = held_q.src1;
        rf_idx2   = held_q.src2;
        out_pc    = held_q.pc;
        out_imm   = held_q.imm;
        out_dst   = held_q.dst;
        out_ctrl  = held_q.ctrl;
        out_op1   = op1;
        out_op2   = op2;
        out_eq    = (op1 == op2);
        stall_cnt = stall_cnt_q;
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        held_d       = held_q;
        stall_cnt_d  = stall_cnt_q;
        if (flush) begin
            hold_valid_d = 1'b0;
        end else if (accept) begin
            hold_valid_d = 1'b1;
        end else if (fire) begin
            hold_valid_d = 1'b0;
        end
        if (accept) begin
            held_d.pc   = in_pc;
            held_d.src1 = in_src1;
            held_d.src2 = in_src2;
            held_d.use1 = in_use1;
            held_d.use2 = in_use2;
            held_d.dst  = in_dst;
            held_d.imm  = in_imm;
            held_d.ctrl = in_ctrl;
        end
        if ((state == ST_INTERLOCK) && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_valid_q <= 1'b0;
            held_q       <= '0;
            stall_cnt_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            held_q       <= held_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Randomised bench for operand_stage with a behavioural model checked every
// cycle, plus directed scenarios pinned to hand-computed values.
module tb_operand_stage;
    import operand_stage_pkg::*;

    localparam int CNT_MAX = 15;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_src1;
    logic [4:0]  in_src2;
    logic        in_use1;
    logic        in_use2;
    logic [4:0]  in_dst;
    logic [31:0] in_imm;
    logic [11:0] in_ctrl;
    logic        flush;
    logic [4:0]  rf_idx1;
    logic [4:0]  rf_idx2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic [2:0]  fwd_valid;
    logic [2:0]  fwd_avail;
    logic [14:0] fwd_dst;
    logic [95:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic        out_eq;
    logic [4:0]  out_dst;
    logic [11:0] out_ctrl;
    logic [3:0]  stall_cnt;

    logic [31:0] regs [32];
    fwd_src_t    fw [3];

    int checks = 0;
    int failures = 0;

    bit   m_hold;
    uop_t m_u;
    int   m_cnt;

    always #5 clk = ~clk;

    assign rf_data1 = regs[rf_idx1];
    assign rf_data2 = regs[rf_idx2];

    always_comb begin
        fwd_valid = '0;
        fwd_avail = '0;
        fwd_dst   = '0;
        fwd_data  = '0;
        for (int i = 0; i < 3; i++) begin
            fwd_valid[i]       = fw[i].valid;
            fwd_avail[i]       = fw[i].avail;
            fwd_dst[i*5 +: 5]  = fw[i].dst;
            fwd_data[i*32 +: 32] = fw[i].data;
        end
    end

    operand_stage #(
        .XLEN   (32),
        .REG_W  (5),
        .NFWD   (3),
        .CTRL_W (12),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_src1   (in_src1),
        .in_src2   (in_src2),
        .in_use1   (in_use1),
        .in_use2   (in_use2),
        .in_dst    (in_dst),
        .in_imm    (in_imm),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .rf_idx1   (rf_idx1),
        .rf_idx2   (rf_idx2),
        .rf_data1  (rf_data1),
        .rf_data2  (rf_data2),
        .fwd_valid (fwd_valid),
        .fwd_avail (fwd_avail),
        .fwd_dst   (fwd_dst),
        .fwd_data  (fwd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_imm   (out_imm),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_eq    (out_eq),
        .out_dst   (out_dst),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // First matching producer in age order decides; no match reads the regfile.
    function automatic void resolve(input logic u, input logic [4:0] s,
                                    output logic [31:0] v, output logic h);
        bit found = 0;
        v = 32'h0;
        h = 1'b0;
        if (u && s != 5'd0) begin
            v = regs[s];
            for (int i = 0; i < 3; i++) begin
                if (!found && fw[i].valid && fw[i].dst == s) begin
                    found = 1;
                    v = fw[i].data;
                    h = !fw[i].avail;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        logic [31:0] e1;
        logic [31:0] e2;
        logic        h1;
        logic        h2;
        logic        ev;
        logic        er;
        if (!resetn) begin
            m_hold = 0;
            m_u    = '0;
            m_cnt  = 0;
        end
        resolve(m_u.use1, m_u.src1, e1, h1);
        resolve(m_u.use2, m_u.src2, e2, h2);
        ev = m_hold && !(h1 || h2);
        er = !flush && (!m_hold || (ev && out_ready));
        chk("m_out_valid", 32'(out_valid), 32'(ev));
        chk("m_in_ready", 32'(in_ready), 32'(er));
        chk("m_out_pc", out_pc, m_u.pc);
        chk("m_out_imm", out_imm, m_u.imm);
        chk("m_out_op1", out_op1, e1);
        chk("m_out_op2", out_op2, e2);
        chk("m_out_eq", 32'(out_eq), 32'(e1 == e2));
        chk("m_out_dst", 32'(out_dst), 32'(m_u.dst));
        chk("m_out_ctrl", 32'(out_ctrl), 32'(m_u.ctrl));
        chk("m_rf_idx1", 32'(rf_idx1), 32'(m_u.src1));
        chk("m_rf_idx2", 32'(rf_idx2), 32'(m_u.src2));
        chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (resetn) begin
            if (m_hold && (h1 || h2) && !flush && m_cnt < CNT_MAX) m_cnt++;
            if (flush) begin
                m_hold = 0;
            end else if (in_valid && er) begin
                m_hold    = 1;
                m_u.pc    = in_pc;
                m_u.src1  = in_src1;
                m_u.src2  = in_src2;
                m_u.use1  = in_use1;
                m_u.use2  = in_use2;
                m_u.dst   = in_dst;
                m_u.imm   = in_imm;
                m_u.ctrl  = in_ctrl;
            end else if (ev && out_ready) begin
                m_hold = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        for (int i = 0; i < 3; i++) fw[i] = '0;
    endtask

    task automatic set_op(input logic [31:0] pc, input logic [4:0] s1,
                          input logic u1, input logic [4:0] s2,
                          input logic u2);
        in_pc   = pc;
        in_src1 = s1;
        in_use1 = u1;
        in_src2 = s2;
        in_use2 = u2;
        in_dst  = 5'(pc[6:2]);
        in_imm  = pc ^ 32'hFFFF_0000;
        in_ctrl = pc[11:0];
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
        clear_fwd();
        resetn    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_op(32'h100, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_eq", 32'(out_eq), 32'h1);
        chk("rst_out_pc", out_pc, 32'h0);
        resetn = 1'b1;
        step();
        chk("first_valid", 32'(out_valid), 32'h1);
        chk("first_pc", out_pc, 32'h100);

        set_op(32'h104, 5'd8, 1'b1, 5'd0, 1'b0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        regs[8]   = 32'hCCCC;
        fw[0]     = '{valid: 1, avail: 1, dst: 5'd8, data: 32'hAAAA};
        fw[2]     = '{valid: 1, avail: 1, dst: 5'd8, data: 32'hBBBB};
        #1 chk("fwd_young", out_op1, 32'hAAAA);
        fw[0].valid = 1'b0;
        #1 chk("fwd_old", out_op1, 32'hBBBB);
        fw[2].valid = 1'b0;
        #1 chk("fwd_rf", out_op1, 32'hCCCC);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_op(32'h108, 5'd0, 1'b1, 5'd0, 1'b0);
        fw[0] = '{valid: 1, avail: 1, dst: 5'd0, data: 32'hDEAD};
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 chk("src_zero", out_op1, 32'h0);

        clear_fwd();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_op(32'h10C, 5'd0, 1'b0, 5'd9, 1'b1);
        fw[0] = '{valid: 1, avail: 0, dst: 5'd9, data: 32'h5555};
        step();
        in_valid = 1'b0;
        chk("lu_stall_valid", 32'(out_valid), 32'h0);
        step();
        chk("lu_stall_cnt", 32'(stall_cnt), 32'h1);
        fw[0].valid = 1'b0;
        fw[1] = '{valid: 1, avail: 1, dst: 5'd9, data: 32'h1234};
        #1 chk("lu_resume_valid", 32'(out_valid), 32'h1);
        chk("lu_resume_op2", out_op2, 32'h1234);

        clear_fwd();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_op(32'h200 + 32'(k * 4), 5'd1, 1'b1, 5'd2, 1'b1);
            step();
            chk("b2b_valid", 32'(out_valid), 32'h1);
            chk("b2b_pc", out_pc, 32'h200 + 32'(k * 4));
        end
        out_ready = 1'b0;
        set_op(32'h240, 5'd0, 1'b0, 5'd0, 1'b0);
        #1 chk("bp_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("bp_pc1", out_pc, 32'h20C);
        step();
        chk("bp_pc2", out_pc, 32'h20C);
        chk("bp_op1", out_op1, 32'h1001);
        out_ready = 1'b1;
        step();
        chk("bp_release_pc", out_pc, 32'h240);

        set_op(32'h300, 5'd10, 1'b1, 5'd0, 1'b0);
        fw[0] = '{valid: 1, avail: 0, dst: 5'd10, data: 32'h0};
        step();
        chk("fl_interlock", 32'(out_valid), 32'h0);
        flush = 1'b1;
        set_op(32'h304, 5'd0, 1'b0, 5'd0, 1'b0);
        #1 chk("fl_in_ready", 32'(in_ready), 32'h0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        clear_fwd();
        #1 chk("fl_out_valid", 32'(out_valid), 32'h0);
        chk("fl_stall_cnt", 32'(stall_cnt), 32'h1);
        chk("fl_not_accepted", out_pc, 32'h300);

        in_valid = 1'b1;
        set_op(32'h400, 5'd3, 1'b1, 5'd4, 1'b1);
        fw[0] = '{valid: 1, avail: 1, dst: 5'd3, data: 32'h5};
        fw[1] = '{valid: 1, avail: 1, dst: 5'd4, data: 32'h5};
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 chk("eq_true", 32'(out_eq), 32'h1);
        fw[1].data = 32'h6;
        #1 chk("eq_false", 32'(out_eq), 32'h0);

        clear_fwd();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_op(32'h500, 5'd11, 1'b1, 5'd0, 1'b0);
        fw[0] = '{valid: 1, avail: 0, dst: 5'd11, data: 32'h0};
        step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("sat_cnt", 32'(stall_cnt), 32'hF);
        clear_fwd();
        step();

        for (int c = 0; c < 3000; c++) begin
            resetn    = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            set_op($urandom, 5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), 1'($urandom));
            in_dst  = 5'($urandom);
            in_ctrl = 12'($urandom);
            for (int i = 0; i < 3; i++) begin
                fw[i].valid = 1'($urandom);
                fw[i].avail = ($urandom_range(0, 3) != 0);
                fw[i].dst   = 5'($urandom_range(0, 7));
                fw[i].data  = $urandom;
            end
            regs[$urandom_range(1, 31)] = $urandom;
            step();
        end
        resetn = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
